// File: rtl/dmem_stall_ctrl.sv
// rtl/dmem_stall_ctrl.sv - MEM-stage data-memory handshake and pipeline stall/flush sequencing
module dmem_stall_ctrl #(
  parameter int DW      = 64,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    ex_mem_ctrl,
  input  logic          ex_mem_valid,
  output logic          dmem_req,
  output logic          dmem_we,
  input  logic          dmem_ack,
  input  logic [DW-1:0] dmem_rdata,
  output logic [DW-1:0] mem_rdata,
  output logic          mem_err,
  input  logic          idex_memread,
  input  logic [4:0]    idex_rd,
  input  logic [4:0]    id_rs,
  input  logic [4:0]    id_rt,
  input  logic [1:0]    id_br,
  input  logic          id_br_eq,
  output logic          pc_write,
  output logic          if2id_write,
  output logic          if2id_flush,
  output logic          pc_sel_br,
  output logic          id2ex_bubble,
  output logic          ex2mem_hold,
  output logic          mem2wb_bubble,
  output logic [15:0]   stall_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // Last WAIT cycle index; an access without ack by then is aborted.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t          state, state_nx;
  logic [7:0]      wait_cnt, wait_cnt_nx;
  logic            req_nx, we_nx, err_nx;
  logic [DW-1:0]   rdata_nx;
  logic [15:0]     stall_cnt_nx;
  logic            acc, mstall, lu, tk;

  // memwrite wins when both control bits are set, so any set bit means an access.
  assign acc    = ex_mem_valid & (ex_mem_ctrl[1] | ex_mem_ctrl[0]);
  // Stall starts combinationally in the detect cycle so the pipeline never advances past the access.
  assign mstall = ((state == ST_IDLE) & acc) | (state == ST_WAIT);
  assign lu     = idex_memread & ((idex_rd == id_rs) | (idex_rd == id_rt));
  assign tk     = ((id_br == 2'b01) & id_br_eq) | ((id_br == 2'b10) & ~id_br_eq);

  // State and registered handshake outputs; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      wait_cnt  <= 8'd0;
      dmem_req  <= 1'b0;
      dmem_we   <= 1'b0;
      mem_err   <= 1'b0;
      mem_rdata <= '0;
      stall_cnt <= 16'd0;
    end else begin
      state     <= state_nx;
      wait_cnt  <= wait_cnt_nx;
      dmem_req  <= req_nx;
      dmem_we   <= we_nx;
      mem_err   <= err_nx;
      mem_rdata <= rdata_nx;
      stall_cnt <= stall_cnt_nx;
    end
  end

  // Next-state logic for the access sequencer; ack beats timeout in the same cycle.
  always_comb begin
    state_nx     = state;
    wait_cnt_nx  = wait_cnt;
    req_nx       = dmem_req;
    we_nx        = dmem_we;
    err_nx       = mem_err;
    rdata_nx     = mem_rdata;
    stall_cnt_nx = (mstall && (stall_cnt != 16'hFFFF)) ? stall_cnt + 16'd1 : stall_cnt;
    unique case (state)
      ST_IDLE: begin
        if (acc) begin
          state_nx    = ST_WAIT;
          req_nx      = 1'b1;
          we_nx       = ex_mem_ctrl[1];
          wait_cnt_nx = 8'd0;
        end
      end
      ST_WAIT: begin
        if (dmem_ack) begin
          state_nx = ST_RELEASE;
          req_nx   = 1'b0;
          we_nx    = 1'b0;
          if (!dmem_we) rdata_nx = dmem_rdata;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nx = ST_RELEASE;
          req_nx   = 1'b0;
          we_nx    = 1'b0;
          err_nx   = 1'b1;
          rdata_nx = '0;
        end else begin
          wait_cnt_nx = wait_cnt + 8'd1;
        end
      end
      // EX/MEM still holds the finished instruction here, so acc is not looked at.
      ST_RELEASE: state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // Pipeline strobes by priority: memory stall, then load-use, then taken branch.
  always_comb begin
    pc_write      = 1'b1;
    if2id_write   = 1'b1;
    if2id_flush   = 1'b0;
    pc_sel_br     = 1'b0;
    id2ex_bubble  = 1'b0;
    ex2mem_hold   = 1'b0;
    mem2wb_bubble = 1'b0;
    if (mstall) begin
      pc_write      = 1'b0;
      if2id_write   = 1'b0;
      ex2mem_hold   = 1'b1;
      mem2wb_bubble = 1'b1;
    end else if (lu) begin
      pc_write     = 1'b0;
      if2id_write  = 1'b0;
      id2ex_bubble = 1'b1;
    end else if (tk) begin
      pc_sel_br   = 1'b1;
      if2id_flush = 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// tb/tb_dmem_stall_ctrl.sv - scoreboard bench for dmem_stall_ctrl
module tb_dmem_stall_ctrl;

  // Strobe order: {pc_write, if2id_write, if2id_flush, pc_sel_br, id2ex_bubble, ex2mem_hold, mem2wb_bubble}
  localparam logic [6:0] S_N = 7'b1100000;
  localparam logic [6:0] S_M = 7'b0000011;
  localparam logic [6:0] S_L = 7'b0000100;
  localparam logic [6:0] S_T = 7'b1111000;

  typedef struct packed {
    logic [6:0]  s;
    logic        req;
    logic        we;
    logic        err;
    logic [63:0] rd;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  ex_mem_ctrl;
  logic        ex_mem_valid;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [63:0] dmem_rdata, mem_rdata;
  logic        mem_err;
  logic        idex_memread;
  logic [4:0]  idex_rd, id_rs, id_rt;
  logic [1:0]  id_br;
  logic        id_br_eq;
  logic        pc_write, if2id_write, if2id_flush, pc_sel_br;
  logic        id2ex_bubble, ex2mem_hold, mem2wb_bubble;
  logic [15:0] stall_cnt;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc_no = 0;

  logic        e_req, e_we, e_err;
  logic [63:0] e_rd;
  logic [15:0] e_cnt;

  dmem_stall_ctrl #(.DW(64), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .ex_mem_ctrl(ex_mem_ctrl), .ex_mem_valid(ex_mem_valid),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_rdata(mem_rdata), .mem_err(mem_err), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .id_rs(id_rs), .id_rt(id_rt), .id_br(id_br), .id_br_eq(id_br_eq), .pc_write(pc_write),
    .if2id_write(if2id_write), .if2id_flush(if2id_flush), .pc_sel_br(pc_sel_br),
    .id2ex_bubble(id2ex_bubble), .ex2mem_hold(ex2mem_hold), .mem2wb_bubble(mem2wb_bubble),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual %h expected %h", name, cyc_no, act, exp);
    end
  endtask

  // Monitor: the DUT presents a full output set every cycle; compare it mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("strobes", 64'({pc_write, if2id_write, if2id_flush, pc_sel_br, id2ex_bubble, ex2mem_hold, mem2wb_bubble}), 64'(e.s));
      chk("req_we_err", 64'({dmem_req, dmem_we, mem_err}), 64'({e.req, e.we, e.err}));
      chk("mem_rdata", mem_rdata, e.rd);
      chk("stall_cnt", 64'(stall_cnt), 64'(e.cnt));
      cyc_no++;
    end
  end

  // Push this cycle's expectation, then advance to just after the next rising edge.
  task automatic cyc(input logic [6:0] s);
    exp_t e;
    e.s = s; e.req = e_req; e.we = e_we; e.err = e_err; e.rd = e_rd; e.cnt = e_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic mem_in(input logic v, input logic [1:0] c, input logic a, input logic [63:0] d);
    ex_mem_valid = v; ex_mem_ctrl = c; dmem_ack = a; dmem_rdata = d;
  endtask

  task automatic id_in(input logic mr, input logic [4:0] rd, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [1:0] br, input logic eq);
    idex_memread = mr; idex_rd = rd; id_rs = rs; id_rt = rt; id_br = br; id_br_eq = eq;
  endtask

  initial begin
    rst_n = 1'b0;
    mem_in(0, 2'b00, 0, 64'd0);
    id_in(0, 5'd1, 5'd2, 5'd3, 2'b00, 0);
    e_req = 0; e_we = 0; e_err = 0; e_rd = 64'd0; e_cnt = 16'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    cyc(S_N);

    // load, ack on 3rd WAIT cycle
    mem_in(1, 2'b01, 0, 64'd0);                          cyc(S_M);
    e_req = 1; e_cnt = 16'd1;                            cyc(S_M);
    e_cnt = 16'd2;                                       cyc(S_M);
    mem_in(1, 2'b01, 1, 64'hDEAD_BEEF_0123_4567); e_cnt = 16'd3; cyc(S_M);
    mem_in(1, 2'b01, 0, 64'd0);
    e_req = 0; e_rd = 64'hDEAD_BEEF_0123_4567; e_cnt = 16'd4; cyc(S_N);
    mem_in(0, 2'b00, 0, 64'd0);                          cyc(S_N);

    // store, ack on 1st WAIT cycle; rdata on the bus must not be captured
    mem_in(1, 2'b10, 0, 64'd0);                          cyc(S_M);
    mem_in(1, 2'b10, 1, 64'h5555_AAAA_5555_AAAA); e_req = 1; e_we = 1; e_cnt = 16'd5; cyc(S_M);
    mem_in(1, 2'b10, 0, 64'd0); e_req = 0; e_we = 0; e_cnt = 16'd6; cyc(S_N);
    // back-to-back access with both control bits set behaves as a write
    mem_in(1, 2'b11, 0, 64'd0);                          cyc(S_M);
    mem_in(1, 2'b11, 1, 64'h1234); e_req = 1; e_we = 1; e_cnt = 16'd7; cyc(S_M);
    mem_in(1, 2'b11, 0, 64'd0); e_req = 0; e_we = 0; e_cnt = 16'd8; cyc(S_N);
    mem_in(0, 2'b00, 0, 64'd0);                          cyc(S_N);

    // load with no ack: 16 WAIT cycles, then abort
    mem_in(1, 2'b01, 0, 64'd0);                          cyc(S_M);
    e_req = 1;
    for (int k = 0; k < 16; k++) begin
      e_cnt = 16'(9 + k);
      cyc(S_M);
    end
    mem_in(1, 2'b01, 1, 64'hFFFF); e_req = 0; e_err = 1; e_rd = 64'd0; e_cnt = 16'd25; cyc(S_N);
    mem_in(0, 2'b00, 1, 64'hFFFF);                       cyc(S_N);
    mem_in(0, 2'b00, 0, 64'd0);                          cyc(S_N);

    // reset asserted mid-WAIT
    mem_in(1, 2'b01, 0, 64'd0);                          cyc(S_M);
    e_req = 1; e_cnt = 16'd26;                           cyc(S_M);
    rst_n = 1'b0; mem_in(0, 2'b00, 0, 64'd0);
    e_req = 0; e_we = 0; e_err = 0; e_rd = 64'd0; e_cnt = 16'd0; cyc(S_N);
    rst_n = 1'b1;                                        cyc(S_N);

    // ack coincides with the timeout cycle: ack wins
    mem_in(1, 2'b01, 0, 64'd0);                          cyc(S_M);
    e_req = 1;
    for (int k = 0; k < 15; k++) begin
      e_cnt = 16'(1 + k);
      cyc(S_M);
    end
    mem_in(1, 2'b01, 1, 64'h1111_2222_3333_4444); e_cnt = 16'd16; cyc(S_M);
    mem_in(1, 2'b01, 0, 64'd0);
    e_req = 0; e_rd = 64'h1111_2222_3333_4444; e_cnt = 16'd17; cyc(S_N);
    mem_in(0, 2'b00, 0, 64'd0);                          cyc(S_N);

    // load-use beats a taken beq, branch resolves after the bubble
    id_in(1, 5'd5, 5'd0, 5'd5, 2'b01, 1);                cyc(S_L);
    id_in(0, 5'd5, 5'd0, 5'd5, 2'b01, 1);                cyc(S_T);
    // register 0 is hazard-checked like any other
    id_in(1, 5'd0, 5'd0, 5'd7, 2'b00, 0);                cyc(S_L);
    // beq not taken, encoding 11 ignored
    id_in(0, 5'd1, 5'd2, 5'd3, 2'b01, 0);                cyc(S_N);
    id_in(0, 5'd1, 5'd2, 5'd3, 2'b11, 1);                cyc(S_N);
    // bne taken with no hazards
    id_in(0, 5'd1, 5'd2, 5'd3, 2'b10, 0);                cyc(S_T);
    // same bne held off by a memory stall until the access releases
    mem_in(1, 2'b01, 0, 64'd0);                          cyc(S_M);
    mem_in(1, 2'b01, 1, 64'hA5); e_req = 1; e_cnt = 16'd18; cyc(S_M);
    mem_in(1, 2'b01, 0, 64'd0); e_req = 0; e_rd = 64'hA5; e_cnt = 16'd19; cyc(S_T);
    mem_in(0, 2'b00, 0, 64'd0); id_in(0, 5'd1, 5'd2, 5'd3, 2'b00, 0); cyc(S_N);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain actual %0d expected 0", exp_q.size());
    end
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
